mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width in bits; DATA_W/8 strobe bits.
REQ-003 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ireq_valid input 1, ireq_ready output 1, ireq_addr input ADDR_W: instruction-fetch read request.
REQ-006 SHALL have ports iresp_valid output 1, iresp_ready input 1, iresp_data output DATA_W: fetch response.
REQ-007 SHALL have ports dreq_valid input 1, dreq_ready output 1, dreq_addr input ADDR_W, dreq_wr input 1, dreq_wdata input DATA_W, dreq_wstrb input DATA_W/8: data request.
REQ-008 SHALL have ports dresp_valid output 1, dresp_ready input 1, dresp_rdata output DATA_W: data response.
REQ-009 SHALL have ports mem_req_valid output 1, mem_req_addr output ADDR_W, mem_req_wr output 1, mem_req_wdata output DATA_W, mem_req_wstrb output DATA_W/8: shared memory port.
REQ-010 SHALL have ports mem_resp_valid input 1, mem_resp_rdata input DATA_W: memory completion, any latency >=1 cycle.

Function
REQ-011 SHALL share one memory port between the two requesters, at most one transaction outstanding.
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: ireq_ready/dreq_ready asserted only toward the granted requester, combinationally, when its valid is high; handshake = valid & ready; transition to ISSUE, latching addr/wr/wdata/wstrb and grant owner.
REQ-014 Arbitration without ARB_RR_EN: data requester wins when both valid.
REQ-015 ISSUE: mem_req_valid=1 for exactly one cycle with latched fields; next state WAIT.
REQ-016 WAIT: hold until mem_resp_valid; latch mem_resp_rdata (writes latch 0); next state RESP.
REQ-017 RESP: assert owner's resp_valid with latched data, held stable until resp_ready; on valid & ready return to IDLE.
REQ-018 Minimum accept-to-response latency: accept cycle N, mem_req_valid N+1, mem_resp_valid earliest N+2, resp_valid N+3.
REQ-019 Next request SHALL be accepted no earlier than the cycle after response handshake (no overlap).
REQ-020 Fetch requests SHALL drive mem_req_wr=0 and mem_req_wstrb=0.
REQ-021 mem_resp_valid outside WAIT SHALL be ignored.
REQ-022 Non-owner resp_valid SHALL remain 0 at all times.

Reset
REQ-023 reset SHALL force state IDLE, grant pointer to data, and all outputs 0 (ready, resp_valid, mem_req_valid, data/address fields) on the next rising edge.
REQ-024 reset mid-transaction SHALL abandon it with no response; a later mem_resp_valid is ignored per REQ-021.

Configuration
REQ-025 Macro ARB_RR_EN SHALL select arbitration: defined -> round-robin, requester that last won loses on next simultaneous request; undefined -> fixed data priority per REQ-014.
REQ-026 With ARB_RR_EN defined, grant pointer SHALL update only on request handshake and reset to data-preferred.

Verification
REQ-027 Fetch only: ireq addr 0x100, memory returns 0x00000013 after 1 cycle -> mem_req_valid cycle N+1 addr 0x100 wr 0, iresp_valid cycle N+3 data 0x00000013.
REQ-028 Data write: addr 0x200 wdata 0xDEADBEEF wstrb 0xF -> mem_req_wr=1 with those fields, dresp_valid once, rdata 0.
REQ-029 Simultaneous ireq/dreq valid for 4 consecutive transactions -> without ARB_RR_EN all grants data; with ARB_RR_EN grants D,I,D,I.
REQ-030 Backpressure: iresp_ready low 5 cycles -> iresp_valid and data stable, no new ireq/dreq accepted, mem_req_valid stays 0.
REQ-031 Reset asserted in WAIT, mem_resp_valid arrives 2 cycles later -> no resp_valid, all outputs 0, next request served normally.
REQ-032 Memory latency 10 cycles -> FSM holds WAIT, mem_req_valid high exactly one cycle, response delivered cycle after completion.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ireq_valid,
  output logic                ireq_ready,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_valid,
  input  logic                iresp_ready,
  output logic [DATA_W-1:0]   iresp_data,
  input  logic                dreq_valid,
  output logic                dreq_ready,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic                dreq_wr,
  input  logic [DATA_W-1:0]   dreq_wdata,
  input  logic [DATA_W/8-1:0] dreq_wstrb,
  output logic                dresp_valid,
  input  logic                dresp_ready,
  output logic [DATA_W-1:0]   dresp_rdata,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic                r_owner_d;
  logic                r_mem_req_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_iresp_valid;
  logic                r_dresp_valid;

  logic w_idle;
  logic w_pref_d;
  logic w_grant_d;
  logic w_ireq_hs;
  logic w_dreq_hs;
  logic w_resp_hs;

  // Ready is gated by reset so a request presented during reset is never lost.
  assign w_idle    = (r_state == S_IDLE) && !reset;
  assign w_grant_d = dreq_valid && (!ireq_valid || w_pref_d);
  assign w_dreq_hs = w_idle && w_grant_d;
  assign w_ireq_hs = w_idle && ireq_valid && !w_grant_d;
  assign w_resp_hs = (r_iresp_valid && iresp_ready) || (r_dresp_valid && dresp_ready);

`ifdef ARB_RR_EN
  logic r_pref_d;

  // The winner of the last handshake yields on the next simultaneous request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pref_d <= 1'b1;
    end else if (w_dreq_hs) begin
      r_pref_d <= 1'b0;
    end else if (w_ireq_hs) begin
      r_pref_d <= 1'b1;
    end
  end

  assign w_pref_d = r_pref_d;
`else
  assign w_pref_d = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_owner_d       <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_addr          <= '0;
      r_wr            <= 1'b0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_rdata         <= '0;
      r_iresp_valid   <= 1'b0;
      r_dresp_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dreq_hs) begin
            r_addr          <= dreq_addr;
            r_wr            <= dreq_wr;
            r_wdata         <= dreq_wdata;
            r_wstrb         <= dreq_wstrb;
            r_owner_d       <= 1'b1;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_ISSUE;
          end else if (w_ireq_hs) begin
            r_addr          <= ireq_addr;
            r_wr            <= 1'b0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_owner_d       <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_req_valid <= 1'b0;
          r_state         <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_rdata       <= r_wr ? '0 : mem_resp_rdata;
            r_iresp_valid <= !r_owner_d;
            r_dresp_valid <= r_owner_d;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_iresp_valid <= 1'b0;
            r_dresp_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ireq_ready    = w_ireq_hs;
  assign dreq_ready    = w_dreq_hs;
  assign iresp_valid   = r_iresp_valid;
  assign iresp_data    = r_rdata;
  assign dresp_valid   = r_dresp_valid;
  assign dresp_rdata   = r_rdata;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_addr;
  assign mem_req_wr    = r_wr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expectations queued at request handshake, checked at response.
// Build with +define+ARB_RR_EN to exercise the round-robin arbitration variant.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          ireq_valid, ireq_ready;
  logic [AW-1:0] ireq_addr;
  logic          iresp_valid, iresp_ready;
  logic [DW-1:0] iresp_data;
  logic          dreq_valid, dreq_ready;
  logic [AW-1:0] dreq_addr;
  logic          dreq_wr;
  logic [DW-1:0] dreq_wdata;
  logic [3:0]    dreq_wstrb;
  logic          dresp_valid, dresp_ready;
  logic [DW-1:0] dresp_rdata;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_wr;
  logic [DW-1:0] mem_req_wdata;
  logic [3:0]    mem_req_wstrb;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
    .iresp_valid(iresp_valid), .iresp_ready(iresp_ready), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_wr(dreq_wr), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
    .dresp_valid(dresp_valid), .dresp_ready(dresp_ready), .dresp_rdata(dresp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: completion arrives mem_lat cycles after the request is seen; writes return junk.
  int            mem_lat = 1;
  int            mem_cnt = 0;
  logic [DW-1:0] mem_pend = '0;

  always @(posedge clock) begin
    mem_resp_valid <= 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        mem_resp_valid <= 1'b1;
        mem_resp_rdata <= mem_pend;
      end
    end else if (mem_req_valid) begin
      if (mem_lat <= 1) begin
        mem_resp_valid <= 1'b1;
        mem_resp_rdata <= mem_req_wr ? 32'hFFFF_FFFF : mem_val(mem_req_addr);
      end else begin
        mem_cnt  <= mem_lat - 1;
        mem_pend <= mem_req_wr ? 32'hFFFF_FFFF : mem_val(mem_req_addr);
      end
    end
  end

  typedef struct packed {logic own_d; logic [31:0] data;} exp_t;
  typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] wstrb;} mreq_t;

  exp_t  sb_q[$];
  mreq_t mq[$];
  logic  glog[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   tcyc = 0;
  int   t_acc = 0;
  bit   t_valid = 1'b0;
  bit   resp_seen = 1'b0;
  bit   hs_i = 1'b0;
  bit   hs_d = 1'b0;
  int   i_left = 0;
  int   d_left = 0;
  logic exp_pref_d = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t  e;
    mreq_t m;
    if (ireq_ready && dreq_ready) check_eq("ready_exclusive", 1, 0);
    if (ireq_valid && dreq_valid && (ireq_ready || dreq_ready)) begin
      check_eq("arb_grant", dreq_ready, exp_pref_d);
      glog.push_back(dreq_ready);
    end
    if (dreq_valid && dreq_ready) begin
      e.own_d = 1'b1;
      e.data  = dreq_wr ? 32'h0 : mem_val(dreq_addr);
      sb_q.push_back(e);
      m.addr = dreq_addr; m.wr = dreq_wr; m.wdata = dreq_wdata; m.wstrb = dreq_wstrb;
      mq.push_back(m);
      hs_d = 1'b1; t_acc = tcyc; t_valid = 1'b1; resp_seen = 1'b0;
`ifdef ARB_RR_EN
      exp_pref_d = 1'b0;
`endif
    end else if (ireq_valid && ireq_ready) begin
      e.own_d = 1'b0;
      e.data  = mem_val(ireq_addr);
      sb_q.push_back(e);
      m.addr = ireq_addr; m.wr = 1'b0; m.wdata = 32'h0; m.wstrb = 4'h0;
      mq.push_back(m);
      hs_i = 1'b1; t_acc = tcyc; t_valid = 1'b1; resp_seen = 1'b0;
`ifdef ARB_RR_EN
      exp_pref_d = 1'b1;
`endif
    end
    if (mem_req_valid) begin
      if (mq.size() == 0) check_eq("mem_req_unexpected", 1, 0);
      else begin
        m = mq.pop_front();
        check_eq("mem_req_addr", mem_req_addr, m.addr);
        check_eq("mem_req_wr", mem_req_wr, m.wr);
        check_eq("mem_req_wdata", mem_req_wdata, m.wdata);
        check_eq("mem_req_wstrb", mem_req_wstrb, m.wstrb);
        if (t_valid) check_eq("req_latency", tcyc - t_acc, 1);
      end
    end
    if (iresp_valid && dresp_valid) check_eq("single_owner_resp", 1, 0);
    if ((iresp_valid || dresp_valid) && t_valid && !resp_seen) begin
      check_eq("resp_latency", tcyc - t_acc, mem_lat + 2);
      resp_seen = 1'b1;
    end
    if ((iresp_valid && iresp_ready) || (dresp_valid && dresp_ready)) begin
      if (sb_q.size() == 0) check_eq("resp_unexpected", 1, 0);
      else begin
        e = sb_q.pop_front();
        check_eq("resp_owner", dresp_valid, e.own_d);
        check_eq("resp_data", dresp_valid ? dresp_rdata : iresp_data, e.data);
        t_valid = 1'b0;
      end
    end
    tcyc++;
  endtask

  task automatic drive_update();
    if (hs_i) begin
      hs_i = 1'b0; i_left--; ireq_addr += 4;
      if (i_left <= 0) ireq_valid = 1'b0;
    end
    if (hs_d) begin
      hs_d = 1'b0; d_left--; dreq_addr += 4;
      if (d_left <= 0) dreq_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    drive_update();
  endtask

  task automatic tick();
    step();
    adv();
  endtask

  task automatic start(input int ni, input logic [31:0] ia, input int nd, input logic [31:0] da,
                       input logic wr, input logic [31:0] wd, input logic [3:0] ws);
    i_left = ni; ireq_addr = ia; ireq_valid = (ni > 0);
    d_left = nd; dreq_addr = da; dreq_wr = wr; dreq_wdata = wd; dreq_wstrb = ws;
    dreq_valid = (nd > 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 400 && (ireq_valid || dreq_valid || sb_q.size() != 0 || mq.size() != 0)) begin
      tick();
      n++;
    end
    check_eq({tag, "_done"}, n < 400, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [3:0]    exp_seq;
    logic [DW-1:0] held;
    int            n;

    reset = 1'b1;
    ireq_valid = 1'b1; ireq_addr = 32'h44;
    dreq_valid = 1'b1; dreq_addr = 32'h88; dreq_wr = 1'b1;
    dreq_wdata = 32'h1234_5678; dreq_wstrb = 4'hF;
    iresp_ready = 1'b1; dresp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ireq_ready", ireq_ready, 0);
    check_eq("rst_dreq_ready", dreq_ready, 0);
    check_eq("rst_iresp_valid", iresp_valid, 0);
    check_eq("rst_dresp_valid", dresp_valid, 0);
    check_eq("rst_mem_req_valid", mem_req_valid, 0);
    check_eq("rst_mem_req_addr", mem_req_addr, 0);
    check_eq("rst_mem_req_wr", mem_req_wr, 0);
    check_eq("rst_mem_req_wdata", mem_req_wdata, 0);
    check_eq("rst_mem_req_wstrb", mem_req_wstrb, 0);
    check_eq("rst_iresp_data", iresp_data, 0);
    check_eq("rst_dresp_rdata", dresp_rdata, 0);
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) tick();

    // Fetch with one-cycle memory
    mem_lat = 1;
    start(1, 32'h100, 0, 32'h0, 1'b0, 32'h0, 4'h0);
    wait_idle("fetch");

    // Four simultaneous requests from each side
    glog.delete();
    start(4, 32'h1000, 4, 32'h2000, 1'b0, 32'h0, 4'h0);
    wait_idle("arb");
`ifdef ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1111;
`endif
    check_eq("arb_count", glog.size() >= 4, 1);
    if (glog.size() >= 4) check_eq("arb_seq", {glog[0], glog[1], glog[2], glog[3]}, exp_seq);

    // Data write
    start(0, 32'h0, 1, 32'h200, 1'b1, 32'hDEAD_BEEF, 4'hF);
    wait_idle("write");

    // Response backpressure with new requests pending
    iresp_ready = 1'b0;
    start(1, 32'h500, 0, 32'h0, 1'b0, 32'h0, 4'h0);
    n = 0;
    while (!iresp_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("bp_resp_arrived", iresp_valid, 1);
    held = iresp_data;
    start(1, 32'h600, 1, 32'h700, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_iresp_valid", iresp_valid, 1);
      check_eq("bp_iresp_data", iresp_data, held);
      check_eq("bp_ireq_ready", ireq_ready, 0);
      check_eq("bp_dreq_ready", dreq_ready, 0);
      check_eq("bp_mem_req_valid", mem_req_valid, 0);
      adv();
    end
    iresp_ready = 1'b1;
    wait_idle("bp");

    // Long memory latency
    mem_lat = 10;
    start(0, 32'h0, 1, 32'h400, 1'b0, 32'h0, 4'h0);
    wait_idle("lat10");

    // Reset while waiting on memory; the late completion must be ignored
    mem_lat = 4;
    start(0, 32'h0, 1, 32'h300, 1'b0, 32'h0, 4'h0);
    n = 0;
    while (!mem_req_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("rstw_req_seen", mem_req_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete(); mq.delete();
    t_valid = 1'b0; hs_i = 1'b0; hs_d = 1'b0;
    i_left = 0; d_left = 0; ireq_valid = 1'b0; dreq_valid = 1'b0;
    exp_pref_d = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("rstw_iresp_valid", iresp_valid, 0);
      check_eq("rstw_dresp_valid", dresp_valid, 0);
      check_eq("rstw_mem_req_valid", mem_req_valid, 0);
      check_eq("rstw_mem_req_addr", mem_req_addr, 0);
      check_eq("rstw_rdata", dresp_rdata, 0);
      adv();
    end

    // Normal service after the abandoned transaction
    mem_lat = 1;
    start(1, 32'h100, 0, 32'h0, 1'b0, 32'h0, 4'h0);
    wait_idle("post_reset");
    start(0, 32'h0, 1, 32'h800, 1'b0, 32'h0, 4'h0);
    wait_idle("post_reset_d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
